// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Pipeline front end sitting directly upstream of instruction_memory_bram.
// Drives the BRAM address from a fetch PC register. It captures the returned
// word one cycle later, together with the PC it was fetched from, into a small
// skid FIFO. Decode drains the FIFO through a valid/ready handshake. A taken
// branch or jump flushes the FIFO, drops the in-flight fetch and restarts
// fetching at the word-aligned target.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  skid buffer entries (2..8)
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   imem_addr        byte address to the BRAM (sampled at the rising edge)
//   imem_rdata       BRAM read word, valid the cycle after the address edge
//   redirect_valid   taken branch/jump this cycle
//   redirect_target  new fetch address (bits [1:0] are forced to zero)
//   inst_valid       inst_data/inst_pc hold a valid instruction
//   inst_ready       decode accepts the head instruction this cycle
//   inst_data        instruction word at the FIFO head
//   inst_pc          byte address of inst_data
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  // Fetch state
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] tag_q,      tag_d;

  // Skid FIFO state
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Per-cycle control
  logic             flush;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and issue control
  // ---------------------------------------------------------------------------
  always_comb begin
    flush = redirect_valid;
    pop   = inst_valid & inst_ready;
    push  = inflight_q & ~flush;
    // Slots committed after this edge: buffered entries, plus the word arriving
    // from the BRAM, minus the one decode takes now. Counting the pop as a
    // credit is what allows one fetch per cycle with only two entries.
    occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    issue     = (occupancy < DEPTH_OCC) & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    tag_d      = tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (flush) begin
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        // 32-bit add wraps FFFF_FFFC -> 0000_0000 on its own.
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_d      = fetch_pc_q;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the outputs below are gated by
  // inst_valid, so stale or unknown entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= tag_q;
      fifo_data_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_addr  = fetch_pc_q;
    inst_valid = (count_q != '0);
    inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit. A behavioural BRAM returns
// 32'hA000_0000 + word_index one cycle after each address edge. Inputs change
// 1 time unit after the rising edge, and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] BASE       = 32'hA000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: word i holds BASE + i.
  always @(posedge clk) imem_rdata <= BASE + {2'b00, imem_addr[31:2]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_pc"},    inst_pc,             pc);
    check({tag, "_data"},  inst_data,           BASE + {2'b00, pc[31:2]});
  endtask

  // The FIFO must never hold more than FIFO_DEPTH entries.
  always @(negedge clk) begin
    if (!reset)
      check("fifo_bound", {31'b0, (int'(dut.count_q) > FIFO_DEPTH)}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b1;
    #3;
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_addr",  imem_addr,           RESET_PC);
    check("rst_pc",    inst_pc,             32'd0);
    check("rst_data",  inst_data,           32'd0);

    // ---- Sequential fetch -------------------------------------------------
    inst_ready = 1'b1;
    do_reset();
    step();
    check("seq_lat1_valid", {31'b0, inst_valid}, 32'd0);
    check("seq_lat1_addr",  imem_addr,           32'h4);
    step();
    expect_inst("seq0", 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_inst($sformatf("seq%0d", i), 32'(4 * i));
    end

    // ---- Backpressure -----------------------------------------------------
    do_reset();
    step();
    step();
    expect_inst("bp_first", 32'h0);
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_inst($sformatf("bp_hold%0d", k), 32'h0);
      check($sformatf("bp_addr%0d", k), imem_addr, 32'h8);
    end
    inst_ready = 1'b1;
    step();
    expect_inst("bp_rel4", 32'h4);
    step();
    expect_inst("bp_rel8", 32'h8);
    step();
    expect_inst("bp_relC", 32'hC);

    // ---- Redirect ---------------------------------------------------------
    do_reset();
    step();
    step();
    step();
    step();
    expect_inst("rd_pre", 32'h8);
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("rd_e1_valid", {31'b0, inst_valid}, 32'd0);
    check("rd_e1_addr",  imem_addr,           32'h40);
    step();
    check("rd_e2_valid", {31'b0, inst_valid}, 32'd0);
    step();
    expect_inst("rd_t0", 32'h40);
    step();
    expect_inst("rd_t1", 32'h44);

    // ---- Misaligned back-to-back redirects ---------------------------------
    redirect_valid  = 1'b1;
    redirect_target = 32'h23;
    step();
    check("bb_addr1",  imem_addr,           32'h20);
    check("bb_valid1", {31'b0, inst_valid}, 32'd0);
    redirect_target = 32'h81;
    step();
    redirect_valid = 1'b0;
    check("bb_addr2",  imem_addr,           32'h80);
    check("bb_valid2", {31'b0, inst_valid}, 32'd0);
    step();
    check("bb_valid3", {31'b0, inst_valid}, 32'd0);
    step();
    expect_inst("bb_t0", 32'h80);
    step();
    expect_inst("bb_t1", 32'h84);

    // ---- Address wrap -----------------------------------------------------
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    expect_inst("wr0", 32'hFFFF_FFF8);
    check("wr0_word", inst_data, 32'hDFFF_FFFE);
    step();
    expect_inst("wr1", 32'hFFFF_FFFC);
    step();
    expect_inst("wr2", 32'h0000_0000);
    step();
    expect_inst("wr3", 32'h0000_0004);

    // ---- Reset mid-stream with a full FIFO --------------------------------
    inst_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    expect_inst("mr_full", 32'h0);
    check("mr_full_addr", imem_addr, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid", {31'b0, inst_valid}, 32'd0);
    check("mr_addr",  imem_addr,           RESET_PC);
    check("mr_pc",    inst_pc,             32'd0);
    check("mr_data",  inst_data,           32'd0);
    step();
    step();
    reset      = 1'b0;
    inst_ready = 1'b1;
    step();
    check("mr_lat1_valid", {31'b0, inst_valid}, 32'd0);
    step();
    expect_inst("mr_first", RESET_PC);
    step();
    expect_inst("mr_second", RESET_PC + 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
